biriscv_v_alu_seq: RTL and testbench

- Multi-cycle, SEW-selectable vector integer ALU for the biRISC-V vector unit.
- Processes one VLEN-wide register group in LANE_W-bit beats.
- Supports .vv and .vx forms, RVV-layout masking, and vl-based tail handling.
- Uses a valid/ready handshake on both the issue side and the writeback side; sits between vector operand read and vector register writeback.

---
 rtl/biriscv_v_alu_seq.sv | 188 ++++++++++++++++++
 tb/tb_biriscv_v_alu_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/biriscv_v_alu_seq.sv
//==============================================================================
// Module   : biriscv_v_alu_seq
// Purpose  : Multi-cycle SEW-selectable vector integer ALU, one LANE_W beat per cycle.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module biriscv_v_alu_seq #(
    parameter int VLEN   = 128,
    parameter int ELEN   = 32,
    parameter int LANE_W = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [3:0]                    op_i,
    input  logic [1:0]                    sew_i,
    input  logic                          vx_i,
    input  logic                          vm_i,
    input  logic [$clog2(VLEN/8):0]       vl_i,
    input  logic [VLEN-1:0]               va_i,
    input  logic [VLEN-1:0]               vb_i,
    input  logic [ELEN-1:0]               scalar_i,
    input  logic [VLEN-1:0]               mask_i,
    input  logic [VLEN-1:0]               vd_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [VLEN-1:0]               result_o,
    output logic                          err_o,
    input  logic                          abort_i
);

    localparam int NBEATS = VLEN / LANE_W;
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int VL_W   = $clog2(VLEN/8) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state, state_next;
    logic [BEAT_W-1:0] beat;
    logic [3:0]        op_q;
    logic [1:0]        sew_q;
    logic              vx_q, vm_q, err_q;
    logic [VL_W-1:0]   vl_q;
    logic [VLEN-1:0]   va_q, vb_q, mask_q, vd_q, result_q, result_next;
    logic [ELEN-1:0]   scalar_q;

    logic [LANE_W-1:0] lane_a, lane_b, lane_vd, lane_res;
    logic [ELEN-1:0]   ea, eb, er;
    logic [VLEN-1:0]   mbits;
    logic              illegal, last_beat;
    int                sh, e;

    assign illegal   = (op_i > 4'd9) || (sew_i == 2'b11);
    assign last_beat = (beat == BEAT_W'(NBEATS - 1));

    // Operands arrive left-aligned in ELEN bits so one routine covers every SEW:
    // wrap-around and signed/unsigned ordering both live in the top SEW bits.
    function automatic logic [ELEN-1:0] elem_op(input logic [3:0] op,
                                                 input logic [ELEN-1:0] a,
                                                 input logic [ELEN-1:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return b - a;
            4'd3:    return (a < b) ? a : b;
            4'd4:    return (a > b) ? a : b;
            4'd5:    return ($signed(a) < $signed(b)) ? a : b;
            4'd6:    return ($signed(a) > $signed(b)) ? a : b;
            4'd7:    return a & b;
            4'd8:    return a | b;
            4'd9:    return a ^ b;
            default: return a;
        endcase
    endfunction

    always_comb begin
        sh       = int'(beat) * LANE_W;
        lane_a   = LANE_W'(va_q >> sh);
        lane_b   = LANE_W'(vb_q >> sh);
        lane_vd  = LANE_W'(vd_q >> sh);
        lane_res = lane_vd;
        ea       = '0;
        eb       = '0;
        er       = '0;
        mbits    = '0;
        e        = 0;
        case (sew_q)
            2'b00: for (int j = 0; j < LANE_W/8; j++) begin
                e     = int'(beat) * (LANE_W/8) + j;
                ea    = {lane_a[j*8 +: 8], {(ELEN-8){1'b0}}};
                eb    = {(vx_q ? scalar_q[7:0] : lane_b[j*8 +: 8]), {(ELEN-8){1'b0}}};
                er    = elem_op(op_q, ea, eb);
                mbits = mask_q >> e;
                if ((e < int'(vl_q)) && (vm_q || mbits[0]))
                    lane_res[j*8 +: 8] = er[ELEN-1 -: 8];
            end
            2'b01: for (int j = 0; j < LANE_W/16; j++) begin
                e     = int'(beat) * (LANE_W/16) + j;
                ea    = {lane_a[j*16 +: 16], {(ELEN-16){1'b0}}};
                eb    = {(vx_q ? scalar_q[15:0] : lane_b[j*16 +: 16]), {(ELEN-16){1'b0}}};
                er    = elem_op(op_q, ea, eb);
                mbits = mask_q >> e;
                if ((e < int'(vl_q)) && (vm_q || mbits[0]))
                    lane_res[j*16 +: 16] = er[ELEN-1 -: 16];
            end
            2'b10: for (int j = 0; j < LANE_W/32; j++) begin
                e     = int'(beat) * (LANE_W/32) + j;
                ea    = lane_a[j*32 +: 32];
                eb    = vx_q ? scalar_q[31:0] : lane_b[j*32 +: 32];
                er    = elem_op(op_q, ea, eb);
                mbits = mask_q >> e;
                if ((e < int'(vl_q)) && (vm_q || mbits[0]))
                    lane_res[j*32 +: 32] = er[31:0];
            end
            default: lane_res = lane_vd;
        endcase
        result_next = (result_q & ~(VLEN'({LANE_W{1'b1}}) << sh)) | (VLEN'(lane_res) << sh);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_next;
    end

    // Illegal requests spend one idle cycle in BUSY so the error response
    // arrives one edge after accept.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (valid_i) state_next = S_BUSY;
            S_BUSY:  if (err_q || last_beat) state_next = S_DONE;
            S_DONE:  if (ready_i) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (abort_i) state_next = S_IDLE;
    end

    always_comb begin
        ready_o  = (state == S_IDLE);
        valid_o  = (state == S_DONE);
        result_o = result_q;
        err_o    = err_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            beat     <= '0;
            op_q     <= '0;
            sew_q    <= '0;
            vx_q     <= 1'b0;
            vm_q     <= 1'b0;
            vl_q     <= '0;
            va_q     <= '0;
            vb_q     <= '0;
            scalar_q <= '0;
            mask_q   <= '0;
            vd_q     <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else if (abort_i) begin
            beat <= '0;
        end else if (state == S_IDLE && valid_i) begin
            beat     <= '0;
            op_q     <= op_i;
            sew_q    <= sew_i;
            vx_q     <= vx_i;
            vm_q     <= vm_i;
            vl_q     <= vl_i;
            va_q     <= va_i;
            vb_q     <= vb_i;
            scalar_q <= scalar_i;
            mask_q   <= mask_i;
            vd_q     <= vd_i;
            result_q <= vd_i;
            err_q    <= illegal;
        end else if (state == S_BUSY && !err_q) begin
            result_q <= result_next;
            beat     <= beat + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_biriscv_v_alu_seq.sv
//==============================================================================
// Module   : tb_biriscv_v_alu_seq
// Purpose  : Random and directed checks of biriscv_v_alu_seq against an element model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_biriscv_v_alu_seq;

    localparam int VLEN   = 128;
    localparam int ELEN   = 32;
    localparam int LANE_W = 64;
    localparam int VL_W   = $clog2(VLEN/8) + 1;

    logic              clk_i = 1'b0, rst_i = 1'b1;
    logic              valid_i = 1'b0, ready_i = 1'b0, abort_i = 1'b0;
    logic              ready_o, valid_o, err_o;
    logic [3:0]        op_i = '0;
    logic [1:0]        sew_i = '0;
    logic              vx_i = 1'b0, vm_i = 1'b1;
    logic [VL_W-1:0]   vl_i = '0;
    logic [VLEN-1:0]   va_i = '0, vb_i = '0, mask_i = '0, vd_i = '0, result_o;
    logic [ELEN-1:0]   scalar_i = '0;

    int                checks = 0, fails = 0;
    logic [VLEN-1:0]   exp_res;
    logic              exp_err;
    bit                exp_live = 0;

    biriscv_v_alu_seq #(.VLEN(VLEN), .ELEN(ELEN), .LANE_W(LANE_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .op_i(op_i), .sew_i(sew_i), .vx_i(vx_i), .vm_i(vm_i), .vl_i(vl_i),
        .va_i(va_i), .vb_i(vb_i), .scalar_i(scalar_i), .mask_i(mask_i), .vd_i(vd_i),
        .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .err_o(err_o),
        .abort_i(abort_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Element-by-element reference: plain integer arithmetic at SEW width.
    function automatic logic [VLEN:0] model(input int op, input int sew, input bit vx, input bit vm,
                                            input int vl, input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
                                            input logic [ELEN-1:0] s, input logic [VLEN-1:0] mask,
                                            input logic [VLEN-1:0] vd);
        int w, n;
        longint m, ae, be, de, sa, sb, r;
        logic [VLEN-1:0] res, mb;
        if (op > 9 || sew == 3) return {1'b1, vd};
        w = 8 << sew;
        n = VLEN / w;
        m = (longint'(1) << w) - 1;
        res = '0;
        for (int e = 0; e < n; e++) begin
            ae = longint'(a >> (e*w)) & m;
            be = vx ? (longint'(s) & m) : (longint'(b >> (e*w)) & m);
            de = longint'(vd >> (e*w)) & m;
            sa = (ae > m/2) ? ae - (m+1) : ae;
            sb = (be > m/2) ? be - (m+1) : be;
            case (op)
                0: r = ae + be;
                1: r = ae - be;
                2: r = be - ae;
                3: r = (ae < be) ? ae : be;
                4: r = (ae > be) ? ae : be;
                5: r = (sa < sb) ? ae : be;
                6: r = (sa > sb) ? ae : be;
                7: r = ae & be;
                8: r = ae | be;
                default: r = ae ^ be;
            endcase
            r &= m;
            mb = mask >> e;
            res |= VLEN'((e < vl && (vm || mb[0])) ? r : de) << (e*w);
        end
        return {1'b0, res};
    endfunction

    // Scoreboard compare: every cycle the result is presented it must match the model.
    always @(negedge clk_i) begin
        if (!rst_i && valid_o) begin
            if (!exp_live) check("spurious_valid", VLEN'(valid_o), '0);
            else begin
                check("result", result_o, exp_res);
                check("err", VLEN'(err_o), VLEN'(exp_err));
            end
        end
    end

    task automatic start_issue(input int op, input int sew, input bit vx, input bit vm, input int vl,
                               input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
                               input logic [ELEN-1:0] s, input logic [VLEN-1:0] mask,
                               input logic [VLEN-1:0] vd);
        logic [VLEN:0] mr;
        @(negedge clk_i);
        check("ready_before_issue", VLEN'(ready_o), 1);
        op_i = 4'(op); sew_i = 2'(sew); vx_i = vx; vm_i = vm; vl_i = VL_W'(vl);
        va_i = a; vb_i = b; scalar_i = s; mask_i = mask; vd_i = vd;
        valid_i = 1'b1;
        mr = model(op, sew, vx, vm, vl, a, b, s, mask, vd);
        exp_err = mr[VLEN];
        exp_res = mr[VLEN-1:0];
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        va_i = {$urandom, $urandom, $urandom, $urandom};
        vd_i = {$urandom, $urandom, $urandom, $urandom};
        scalar_i = $urandom;
        op_i = 4'($urandom);
    endtask

    task automatic wait_valid(input int exp_lat);
        int lat = 0;
        do begin
            @(posedge clk_i);
            #1;
            lat++;
        end while (!valid_o && lat < 12);
        check("latency", VLEN'(lat), VLEN'(exp_lat));
    endtask

    task automatic finish_handshake(input int hold);
        repeat (hold) @(negedge clk_i);
        @(negedge clk_i);
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        ready_i = 1'b0;
        exp_live = 0;
        check("ready_after_handshake", VLEN'({ready_o, valid_o}), VLEN'(2'b10));
    endtask

    task automatic run(input int op, input int sew, input bit vx, input bit vm, input int vl,
                       input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
                       input logic [ELEN-1:0] s, input logic [VLEN-1:0] mask,
                       input logic [VLEN-1:0] vd, input int hold, output logic [VLEN-1:0] got);
        start_issue(op, sew, vx, vm, vl, a, b, s, mask, vd);
        exp_live = 1;
        wait_valid(exp_err ? 1 : 2);
        got = result_o;
        finish_handshake(hold);
    endtask

    initial begin
        logic [VLEN-1:0] got, a, b;
        repeat (3) @(negedge clk_i);
        check("reset_outputs", VLEN'({ready_o, valid_o, err_o}), VLEN'(3'b100));
        check("reset_result", result_o, '0);
        rst_i = 1'b0;

        run(0, 2, 0, 1, 4, {32'd4, 32'd3, 32'd2, 32'd1}, {32'hFFFFFFFF, 32'd10, 32'd20, 32'd30},
            '0, '0, '0, 0, got);
        check("add32_literal", got, 128'h00000003_0000000D_00000016_0000001F);

        a = 128'h017F;
        run(5, 0, 1, 1, 2, a, '0, 32'h80, '0, '0, 1, got);
        check("min8_literal", got, 128'h8080);
        run(3, 0, 1, 1, 2, a, '0, 32'h80, '0, '0, 0, got);
        check("minu8_literal", got, 128'h017F);

        a = {8{16'h0001}};
        run(0, 1, 0, 0, 6, a, a, '0, 128'h00AA, {8{16'hBEEF}}, 5, got);
        check("masked_add16_literal", got, 128'hBEEF_BEEF_0002_BEEF_0002_BEEF_0002_BEEF);

        run(0, 3, 0, 1, 4, a, a, '0, '0, 128'h1234_5678, 0, got);
        check("illegal_sew_literal", got, 128'h1234_5678);
        run(12, 0, 0, 1, 4, a, a, '0, '0, 128'h9ABC, 2, got);
        check("illegal_op_literal", got, 128'h9ABC);

        run(0, 0, 0, 1, 0, a, a, '0, '0, 128'h5555, 0, got);
        check("vl0_literal", got, 128'h5555);

        for (int i = 0; i < 60; i++) begin
            a = {$urandom, $urandom, $urandom, $urandom};
            b = {$urandom, $urandom, $urandom, $urandom};
            run(($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9),
                ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2),
                1'($urandom), 1'($urandom), $urandom_range(0, 20), a, b, $urandom,
                {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                $urandom_range(0, 3), got);
        end

        // Abort during beat 0: back to idle at the next edge, no result ever presented.
        start_issue(0, 0, 0, 1, 16, a, b, '0, '0, '0);
        @(negedge clk_i);
        abort_i = 1'b1;
        @(posedge clk_i);
        #1;
        abort_i = 1'b0;
        check("abort_idle", VLEN'({ready_o, valid_o}), VLEN'(2'b10));
        repeat (4) @(negedge clk_i);

        // Asynchronous reset while the result waits in DONE.
        start_issue(9, 1, 0, 1, 8, a, b, '0, '0, '0);
        exp_live = 1;
        wait_valid(2);
        @(negedge clk_i);
        exp_live = 0;
        rst_i = 1'b1;
        #1;
        check("reset_in_done_flags", VLEN'({ready_o, valid_o, err_o}), VLEN'(3'b100));
        check("reset_in_done_result", result_o, '0);
        @(negedge clk_i);
        rst_i = 1'b0;

        run(6, 2, 1, 1, 31, a, b, 32'h8000_0001, '0, '0, 0, got);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire
